// File: rtl/pos_bcd_encoder_pkg.sv
// Shared types and constants for the cursor position BCD encoder.
// State encoding, invalid-digit code and the double-dabble nibble adjust.
package pos_bcd_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT_X = 2'd1,
        ST_SHIFT_Y = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    localparam int         BCD_SCRATCH_W = 16;
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/pos_bcd_encoder_dabble.sv
// One double-dabble iteration: add-3 on every nibble >= 5,
// then shift left by one with the next operand bit entering the LSB.
module dabble_step
    import pos_bcd_encoder_pkg::*;
(
    input  logic [BCD_SCRATCH_W-1:0] scratch_i,
    input  logic                     bit_i,
    output logic [BCD_SCRATCH_W-1:0] scratch_o
);

    logic [BCD_SCRATCH_W-1:0] adj;

    always_comb begin
        adj = scratch_i;
        for (int i = 0; i < BCD_SCRATCH_W / 4; i++) begin
            adj[4*i +: 4] = add3(scratch_i[4*i +: 4]);
        end
    end

    assign scratch_o = {adj[BCD_SCRATCH_W-2:0], bit_i};

endmodule

// File: rtl/pos_bcd_encoder.sv
// Iterative binary-to-BCD encoder for the cursor cell position.
// One dabble datapath is time-shared: X first, then Y, then an atomic output update.
module pos_bcd_encoder
    import pos_bcd_encoder_pkg::*;
#(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 7,
    parameter int X_MAX   = 999,
    parameter int Y_MAX   = 99
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_WIDTH-1:0] x_pos,
    input  logic [Y_WIDTH-1:0] y_pos,
    output logic               busy,
    output logic               done,
    output logic [3:0]         x_ones,
    output logic [3:0]         x_tens,
    output logic [3:0]         x_huns,
    output logic [3:0]         y_ones,
    output logic [3:0]         y_tens
);

    localparam int MAX_W = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [X_WIDTH-1:0] X_MAX_V = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] Y_MAX_V = Y_WIDTH'(Y_MAX);

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [X_WIDTH-1:0]       x_op_q;
    logic [Y_WIDTH-1:0]       y_op_q;
    logic                     x_oor_q;
    logic                     y_oor_q;
    logic [BCD_SCRATCH_W-1:0] scratch_q;
    logic [BCD_SCRATCH_W-1:0] scratch_d;
    logic [11:0]              x_stage_q;
    logic                     busy_q;
    logic                     done_q;
    logic [3:0]               x_ones_q;
    logic [3:0]               x_tens_q;
    logic [3:0]               x_huns_q;
    logic [3:0]               y_ones_q;
    logic [3:0]               y_tens_q;
    logic                     shift_bit;

    assign shift_bit = (state_q == ST_SHIFT_X) ? x_op_q[X_WIDTH-1]
                                               : y_op_q[Y_WIDTH-1];

    dabble_step u_dabble (
        .scratch_i (scratch_q),
        .bit_i     (shift_bit),
        .scratch_o (scratch_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            x_op_q    <= '0;
            y_op_q    <= '0;
            x_oor_q   <= 1'b0;
            y_oor_q   <= 1'b0;
            scratch_q <= '0;
            x_stage_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            x_ones_q  <= 4'd0;
            x_tens_q  <= 4'd0;
            x_huns_q  <= 4'd0;
            y_ones_q  <= 4'd0;
            y_tens_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_op_q    <= x_pos;
                        y_op_q    <= y_pos;
                        x_oor_q   <= (x_pos > X_MAX_V);
                        y_oor_q   <= (y_pos > Y_MAX_V);
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(X_WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT_X;
                    end
                end
                ST_SHIFT_X: begin
                    x_op_q <= x_op_q << 1;
                    if (cnt_q == CNT_W'(1)) begin
                        x_stage_q <= scratch_d[11:0];
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(Y_WIDTH);
                        state_q   <= ST_SHIFT_Y;
                    end else begin
                        scratch_q <= scratch_d;
                        cnt_q     <= cnt_q - CNT_W'(1);
                    end
                end
                ST_SHIFT_Y: begin
                    y_op_q    <= y_op_q << 1;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    // all five digits change on this one edge
                    x_huns_q <= x_oor_q ? DIGIT_INVALID : x_stage_q[11:8];
                    x_tens_q <= x_oor_q ? DIGIT_INVALID : x_stage_q[7:4];
                    x_ones_q <= x_oor_q ? DIGIT_INVALID : x_stage_q[3:0];
                    y_tens_q <= y_oor_q ? DIGIT_INVALID : scratch_q[7:4];
                    y_ones_q <= y_oor_q ? DIGIT_INVALID : scratch_q[3:0];
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign x_ones = x_ones_q;
    assign x_tens = x_tens_q;
    assign x_huns = x_huns_q;
    assign y_ones = y_ones_q;
    assign y_tens = y_tens_q;

endmodule
